// File: rtl/multicycle_adder.sv
// multicycle_adder: N-bit a + b + c_in computed CHUNK bits per cycle through a registered carry.
// Latency: out_valid rises N/CHUNK cycles after the accept edge; one op per N/CHUNK + 2 cycles.
// Backpressure: in_ready only in IDLE; out_ready low holds DONE with outputs frozen. Macro: MULTICYCLE_ADDER_OVF_EN.
module multicycle_adder #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         out_valid,
  input  logic         out_ready
`ifdef MULTICYCLE_ADDER_OVF_EN
  ,
  output logic         overflow
`endif
);

  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  generate
    if ((CHUNK < 1) || (N % CHUNK != 0)) begin : g_bad_chunk
      $error("multicycle_adder: N must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   chunk_sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Only a CHUNK-bit adder on the current slice; the carry between slices is registered.
  always_comb begin
    a_sl      = a_r[int'(idx)*CHUNK +: CHUNK];
    b_sl      = b_r[int'(idx)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
  end

  // Control FSM and datapath registers; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry <= chunk_sum[CHUNK];
          if (idx == LAST_IDX) begin
            c_out <= chunk_sum[CHUNK];
`ifdef MULTICYCLE_ADDER_OVF_EN
            // Carry into bit N-1 is a ^ b ^ sum at that bit; XOR with carry out gives signed overflow.
            overflow <= a_r[N-1] ^ b_r[N-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
`endif
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
